// File: rtl/dpll_step_stim.sv
// Reference NCO with programmable phase/frequency/ramp perturbation and a
// settle-time meter that waits for the DUT feedback phase to hold a lock window.
module dpll_step_stim #(
    parameter int PW       = 16,
    parameter int DW       = 16,
    parameter int TW       = 20,
    parameter int LOCK_CNT = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [PW-1:0] fcw,
    input  logic [1:0]    mode,
    input  logic [PW-1:0] step_val,
    input  logic [DW-1:0] delay,
    input  logic [DW-1:0] ramp_len,
    input  logic [PW-2:0] lock_thr,
    input  logic          arm,
    input  logic [PW-1:0] fb_phase,
    output logic [PW-1:0] ref_phase,
    output logic          ref_tick,
    output logic          busy,
    output logic          done,
    output logic [TW-1:0] settle_cycles,
    output logic          timeout
);
    localparam int RW = $clog2(LOCK_CNT + 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_APPLY, S_SETTLE, S_DONE} state_t;

    state_t        state, state_n;
    logic [PW-1:0] acc, off, fstep, step_q;
    logic [PW-1:0] acc_n, off_n, fstep_n, diff;
    logic [1:0]    mode_q;
    logic [DW-1:0] ramp_q, cnt, cnt_n;
    logic [TW-1:0] timer, timer_n, settle_n;
    logic [RW-1:0] run, run_n;
    logic          timeout_n, msb_d, in_win, timer_sat, accept;
    logic signed [PW:0] err, thr;

    assign acc_n     = acc + fcw + fstep;
    assign diff      = ref_phase - fb_phase;
    // One extra bit keeps -thr representable; -2^(PW-1) can never be in-window.
    assign err       = {diff[PW-1], diff};
    assign thr       = {2'b00, lock_thr};
    assign in_win    = (err <= thr) && (err >= -thr);
    assign timer_sat = (timer == '1);
    assign accept    = arm && (state == S_IDLE || state == S_DONE);
    assign busy      = (state == S_WAIT) || (state == S_APPLY) || (state == S_SETTLE);
    assign done      = (state == S_DONE);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        off_n     = off;
        fstep_n   = fstep;
        timer_n   = timer;
        run_n     = run;
        settle_n  = settle_cycles;
        timeout_n = timeout;
        if ((state == S_APPLY || state == S_SETTLE) && !timer_sat)
            timer_n = timer + 1'b1;
        case (state)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_n   = S_WAIT;
                    cnt_n     = delay;
                    timer_n   = '0;
                    run_n     = '0;
                    settle_n  = '0;
                    timeout_n = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_n = S_APPLY;
                    timer_n = '0;
                    // cnt is reused as the ramp cycle counter; ramp_len 0 acts as 1
                    cnt_n   = (ramp_q == '0) ? '0 : ramp_q - 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_APPLY: begin
                fstep_n = (mode_q == 2'd1) ? step_q : '0;
                if (mode_q == 2'd0 || mode_q == 2'd2)
                    off_n = off + step_q;
                if (mode_q != 2'd2 || cnt == '0)
                    state_n = S_SETTLE;
                else
                    cnt_n = cnt - 1'b1;
            end
            S_SETTLE: begin
                if (ref_tick)
                    run_n = in_win ? run + 1'b1 : '0;
                // lock is tested first so a lock on the saturating cycle wins
                if (ref_tick && in_win && run == RW'(LOCK_CNT - 1)) begin
                    settle_n = timer;
                    state_n  = S_DONE;
                end else if (timer_sat) begin
                    settle_n  = '1;
                    timeout_n = 1'b1;
                    state_n   = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            acc           <= '0;
            off           <= '0;
            fstep         <= '0;
            step_q        <= '0;
            mode_q        <= '0;
            ramp_q        <= '0;
            cnt           <= '0;
            timer         <= '0;
            run           <= '0;
            settle_cycles <= '0;
            timeout       <= 1'b0;
            ref_phase     <= '0;
            ref_tick      <= 1'b0;
            msb_d         <= 1'b0;
        end else begin
            state         <= state_n;
            acc           <= acc_n;
            off           <= off_n;
            fstep         <= fstep_n;
            cnt           <= cnt_n;
            timer         <= timer_n;
            run           <= run_n;
            settle_cycles <= settle_n;
            timeout       <= timeout_n;
            ref_phase     <= acc_n + off_n;
            msb_d         <= ref_phase[PW-1];
            ref_tick      <= ref_phase[PW-1] & ~msb_d;
            if (accept) begin
                mode_q <= mode;
                step_q <= step_val;
                ramp_q <= ramp_len;
            end
        end
    end
endmodule

// File: tb/tb_dpll_step_stim.sv
// Bench for dpll_step_stim: run-schedule reference model, directed literal
// checks for the documented scenarios, then randomized runs.
module tb_dpll_step_stim;
    localparam int PW = 16, DW = 16, TW = 8, LOCK_CNT = 8;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic [15:0]   fcw, step_val, fb_phase, fb_hold, fb_err, delay, ramp_len;
    logic [1:0]    mode;
    logic [14:0]   lock_thr;
    logic          arm, fb_track;
    logic [15:0]   ref_phase;
    logic          ref_tick, busy, done, timeout;
    logic [7:0]    settle_cycles;
    int            total = 0, bad = 0;

    always #5 clk = ~clk;

    assign fb_phase = fb_track ? 16'(ref_phase + fb_err) : fb_hold;

    dpll_step_stim #(.PW(PW), .DW(DW), .TW(TW), .LOCK_CNT(LOCK_CNT)) dut (
        .clk(clk), .reset_n(reset_n), .fcw(fcw), .mode(mode), .step_val(step_val),
        .delay(delay), .ramp_len(ramp_len), .lock_thr(lock_thr), .arm(arm),
        .fb_phase(fb_phase), .ref_phase(ref_phase), .ref_tick(ref_tick), .busy(busy),
        .done(done), .settle_cycles(settle_cycles), .timeout(timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is a schedule indexed by cycles since the arm edge
    // (WAIT for delay+1 cycles, APPLY for len cycles, then SETTLE).
    logic [15:0]       m_acc, m_off, m_fstep, m_ref, m_ref_d1, r_step;
    logic [15:0]       acc_new, off_new, fstep_new;
    logic              m_tick, m_busy, m_done, m_tmo;
    logic [7:0]        m_settle;
    logic signed [15:0] ev;
    int                rel, r_mode, r_delay, r_len, run, tmr;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_acc = 0; m_off = 0; m_fstep = 0; m_ref = 0; m_ref_d1 = 0;
            m_tick = 0; m_busy = 0; m_done = 0; m_tmo = 0; m_settle = 0;
            rel = 0; run = 0;
        end else begin
            acc_new = m_acc + fcw + m_fstep;
            off_new = m_off;
            fstep_new = m_fstep;
            if (m_busy) begin
                if (rel > r_delay && rel <= r_delay + r_len) begin
                    if (r_mode == 0 || r_mode == 2) off_new = m_off + r_step;
                    fstep_new = (r_mode == 1) ? r_step : 16'h0;
                end else if (rel > r_delay + r_len) begin
                    tmr = rel - r_delay - 1;
                    if (tmr > 255) tmr = 255;
                    if (m_tick) begin
                        ev = m_ref - fb_phase;
                        if (int'(ev) >= -int'(lock_thr) && int'(ev) <= int'(lock_thr)) run++;
                        else run = 0;
                    end
                    if (m_tick && run == LOCK_CNT) begin
                        m_busy = 0; m_done = 1; m_settle = 8'(tmr);
                    end else if (tmr == 255) begin
                        m_busy = 0; m_done = 1; m_settle = 8'hFF; m_tmo = 1;
                    end
                end
                rel++;
            end else if (arm) begin
                m_busy = 1; m_done = 0; m_tmo = 0; m_settle = 0; rel = 0; run = 0;
                r_mode = int'(mode); r_delay = int'(delay); r_step = step_val;
                r_len = (mode == 2'd2) ? ((ramp_len == 0) ? 1 : int'(ramp_len)) : 1;
            end
            m_tick = m_ref[15] & ~m_ref_d1[15];
            m_ref_d1 = m_ref;
            m_acc = acc_new;
            m_off = off_new;
            m_fstep = fstep_new;
            m_ref = acc_new + off_new;
        end
    end

    initial forever begin
        @(negedge clk); #1;
        chk("ref_phase", ref_phase, m_ref);
        chk("ref_tick", ref_tick, m_tick);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("settle_cycles", settle_cycles, m_settle);
        chk("timeout", timeout, m_tmo);
    end

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL wait_done: done=0 want 1 within %0d cycles", budget);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ticks, t;
        logic [15:0] ph [0:7];
        logic [15:0] p0;
        fcw = 16'h1000; mode = 2'd3; step_val = 0; delay = 0; ramp_len = 0;
        lock_thr = 0; arm = 0; fb_track = 1; fb_err = 0; fb_hold = 0;
        repeat (3) @(negedge clk);
        chk("rst_ref_phase", ref_phase, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset_n = 1'b1;

        // mode 3, exact tracking: arm sampled at edge 20, first SETTLE tick at timer 4
        repeat (19) @(negedge clk);
        pulse_arm();
        wait_done(400, n);
        chk("m3_settle", settle_cycles, 116);
        chk("m3_timeout", timeout, 0);

        // mode 0 phase step lands 7 cycles after the arm edge
        mode = 2'd0; step_val = 16'h4000; delay = 5;
        pulse_arm();
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            ph[i] = ref_phase;
        end
        chk("m0_before", 16'(ph[6] - ph[5]), 16'h1000);
        chk("m0_jump", 16'(ph[7] - ph[6]), 16'h5000);
        wait_done(400, n);

        // mode 1 frequency step: 0x1100 per cycle
        mode = 2'd1; step_val = 16'h0100; delay = 0;
        pulse_arm();
        repeat (3) @(negedge clk);
        ticks = 0;
        for (int i = 0; i < 3630; i++) begin
            @(negedge clk);
            ticks += int'(ref_tick);
        end
        chk("m1_ticks_in_240_242", 32'(ticks >= 240 && ticks <= 242), 1);
        wait_done(400, n);

        // mode 3 run clears fstep at APPLY
        mode = 2'd3;
        pulse_arm();
        wait_done(400, n);

        // mode 2 ramp, ramp_len 0 then 100
        mode = 2'd2; step_val = 16'h0001; ramp_len = 0;
        pulse_arm();
        p0 = ref_phase;
        repeat (30) @(negedge clk);
        chk("m2_ramp0", 16'(ref_phase - p0), 16'hE001);
        wait_done(400, n);
        ramp_len = 100;
        pulse_arm();
        p0 = ref_phase;
        repeat (150) @(negedge clk);
        chk("m2_ramp100", 16'(ref_phase - p0), 16'h6064);
        wait_done(400, n);

        // frozen feedback: timer saturates
        fb_track = 0; fb_hold = 16'h1234; mode = 2'd3; delay = 2;
        pulse_arm();
        wait_done(400, n);
        chk("to_cycles", n, 259);
        chk("to_settle", settle_cycles, 8'hFF);
        chk("to_timeout", timeout, 1);

        // arm during WAIT must not disturb the run
        fb_track = 1; mode = 2'd3; delay = 20;
        pulse_arm();
        p0 = ref_phase;
        repeat (4) @(negedge clk);
        mode = 2'd0; step_val = 16'h7000; delay = 1;
        pulse_arm();
        mode = 2'd3;
        repeat (35) @(negedge clk);
        chk("wait_arm_ignored", 16'(ref_phase - p0), 16'h8000);
        chk("wait_busy", busy, 1);
        wait_done(400, n);

        // reset during SETTLE with a frequency step in force
        mode = 2'd1; step_val = 16'h0200; delay = 0;
        pulse_arm();
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ref", ref_phase, 0);
        chk("rstmid_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rstmid_fstep0_a", ref_phase, 16'h1000);
        @(negedge clk);
        chk("rstmid_fstep0_b", ref_phase, 16'h2000);

        // randomized runs
        for (int k = 0; k < 40; k++) begin
            fcw = 16'($urandom_range(16'h0800, 16'h2000));
            mode = 2'($urandom_range(0, 3));
            step_val = 16'($urandom);
            delay = 16'($urandom_range(0, 20));
            ramp_len = 16'($urandom_range(0, 30));
            lock_thr = 15'($urandom_range(0, 64));
            fb_err = 0;
            pulse_arm();
            t = int'(lock_thr) + 8;
            n = 0;
            while (!done && n < 600) begin
                fb_err = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2 * t) - t) : 16'h0;
                arm = busy && ($urandom_range(0, 7) == 0);
                if (arm) begin
                    mode = 2'($urandom_range(0, 3));
                    step_val = 16'($urandom);
                end
                @(negedge clk);
                arm = 1'b0;
                n++;
            end
            total++;
            if (!done) begin
                bad++;
                $display("FAIL rand_done: run %0d done=0 want 1 within 600 cycles", k);
            end
        end

        repeat (2) @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
